// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared definitions for the ALU command sequencer.
//   - OP_W / DATA_W / RES_W / SEL_W / CNT_W : bus widths
//   - RA_SEL / RB_SEL / RZ_SEL             : bit positions in register_select
//   - state_t                              : sequencer state encoding
//   - sel_bit()                            : one-hot strobe for a select index
package alu_sequencer_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int SEL_W  = 16;
  localparam int CNT_W  = 4;

  localparam int RA_SEL = 0;
  localparam int RB_SEL = 1;
  localparam int RZ_SEL = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_CAPT   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  function automatic logic [SEL_W-1:0] sel_bit(input int idx);
    sel_bit = SEL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, response and datapath-control signals of the
// ALU sequencer.
//   slave  : the sequencer (accepts commands, drives datapath and response)
//   master : the environment (issues commands, supplies rz_data, takes results)
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OP_W-1:0]     cmd_op;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic [OP_W-1:0]     op_select;
  logic [SEL_W-1:0]    register_select;
  logic [DATA_W-1:0]   register_in;
  logic [RES_W-1:0]    rz_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RES_W-1:0]    rsp_result;
  logic                rsp_error;
  logic                busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rz_data, rsp_ready,
    output cmd_ready, op_select, register_select, register_in,
           rsp_valid, rsp_result, rsp_error, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rz_data, rsp_ready,
    input  cmd_ready, op_select, register_select, register_in,
           rsp_valid, rsp_result, rsp_error, busy
  );

endinterface

// File: rtl/alu_sequencer_wait_counter.sv
// alu_seq_wait_counter: 4-bit loadable down-counter with a zero flag.
//   clock, clear(async active-low)
//   load     : load load_val (has priority over dec)
//   dec      : decrement, holding at zero
//   load_val : value to load
//   zero     : count is zero
module alu_seq_wait_counter
  import alu_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_p0 <= '0;
    end else if (load) begin
      cnt_p0 <= load_val;
    end else if (dec && (cnt_p0 != '0)) begin
      cnt_p0 <= cnt_p0 - 1'b1;
    end
  end

  assign zero = (cnt_p0 == '0);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command over a valid/ready handshake, walks
// the datapath through load-A, load-B, execute and capture-Z, then returns
// the 64-bit Z register over a second valid/ready handshake.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : alu_sequencer_if.slave (cmd_*, rsp_*, op_select, register_select,
//           register_in, rz_data, busy)
// Parameters: EXEC_CYCLES (1..15) cycles op_select is held before capture;
//             NUM_OPS number of legal opcodes.
// Macro ALU_SEQ_ILLEGAL_OP_EN: opcodes >= NUM_OPS skip the datapath and answer
// with rsp_error=1, rsp_result=0. Without it every opcode is sequenced and
// rsp_error stays 0.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int NUM_OPS     = 12
) (
  input  logic            clock,
  input  logic            clear,
  alu_sequencer_if.slave  bus
);

  state_t            state_p0, next_state;
  logic [OP_W-1:0]   op_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic              accept;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  assign accept = (state_p0 == ST_IDLE) && bus.cmd_valid;

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic illegal;
  logic err_p0;

  assign illegal = (int'(bus.cmd_op) >= NUM_OPS);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      err_p0 <= 1'b0;
    end else if (accept) begin
      err_p0 <= illegal;
    end
  end
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_p0 <= ST_IDLE;
      op_p0    <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
    end else begin
      state_p0 <= next_state;
      // Operands are captured once; the producer may change them afterwards.
      if (accept) begin
        op_p0 <= bus.cmd_op;
        a_p0  <= bus.cmd_a;
        b_p0  <= bus.cmd_b;
      end
    end
  end

  // Loaded in LOAD_B so the count reaches zero on the last EXEC cycle.
  alu_seq_wait_counter u_wait (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(EXEC_CYCLES - 1)),
    .zero     (cnt_zero)
  );

  always_comb begin
    next_state          = state_p0;
    bus.cmd_ready       = 1'b0;
    bus.op_select       = op_p0;
    bus.register_select = '0;
    bus.register_in     = '0;
    bus.rsp_valid       = 1'b0;
    bus.rsp_result      = '0;
    bus.rsp_error       = 1'b0;
    bus.busy            = 1'b1;
    cnt_load            = 1'b0;
    cnt_dec             = 1'b0;

    case (state_p0)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        bus.op_select = '0;
        if (bus.cmd_valid) begin
`ifdef ALU_SEQ_ILLEGAL_OP_EN
          next_state = illegal ? ST_RESP : ST_LOAD_A;
`else
          next_state = ST_LOAD_A;
`endif
        end
      end
      ST_LOAD_A: begin
        bus.register_in     = a_p0;
        bus.register_select = sel_bit(RA_SEL);
        next_state          = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        bus.register_in     = b_p0;
        bus.register_select = sel_bit(RB_SEL);
        cnt_load            = 1'b1;
        next_state          = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          next_state = ST_CAPT;
        end
      end
      ST_CAPT: begin
        bus.register_select = sel_bit(RZ_SEL);
        next_state          = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
        bus.rsp_error  = err_p0;
        bus.rsp_result = err_p0 ? '0 : bus.rz_data;
`else
        bus.rsp_result = bus.rz_data;
`endif
        if (bus.rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven control sequencer that sits directly upstream of the ALU datapath. It accepts one ALU command (opcode plus two 32-bit operands) over a valid/ready handshake, then walks the datapath through load-A, load-B, execute and capture-Z. It drives the datapath's `op_select`, `register_select` and `register_in` inputs, and returns the 64-bit Z result over a second valid/ready handshake.

## Interface
Parameters:
- `EXEC_CYCLES`, 1: cycles `op_select` is held stable before the Z capture. Legal range 1..15; covers multi-cycle ALU paths.
- `NUM_OPS`, 12: number of legal opcodes. Opcodes 0..NUM_OPS-1 are legal.

Ports:
- `clock`  in  1  sole clock; everything is sampled on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  4  ALU opcode.
- `cmd_a`  in  32  operand A.
- `cmd_b`  in  32  operand B.
- `op_select`  out  4  opcode to the datapath ALU.
- `register_select`  out  16  one-hot load strobes: bit0 RA, bit1 RB, bit2 RZ; bits 15:3 are always 0.
- `register_in`  out  32  operand bus to RA/RB.
- `rz_data`  in  64  datapath RZ register output ({hi, lo}).
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_result`  out  64  result.
- `rsp_error`  out  1  illegal-opcode flag (see Configuration).
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch op/a/b and go to LOAD_A. Inputs are not sampled again after acceptance.
- LOAD_A: `register_in`=a, `register_select`[0]=1, then go to LOAD_B.
- LOAD_B: `register_in`=b, `register_select`[1]=1, then go to EXEC. Load the wait counter with EXEC_CYCLES-1.
- EXEC:
  - `register_select`=0.
  - Count down; go to CAPT when the count is 0.
- CAPT: `register_select`[2]=1 for exactly one cycle, then go to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_result`=`rz_data` (pass-through; RZ is not strobed while in RESP, so the value is stable).
  - On `rsp_ready`, go to IDLE.
- `op_select` shows the latched opcode from LOAD_A through RESP, and 0 in IDLE.
- `register_in`=0 outside LOAD_A and LOAD_B.
- At most one bit of `register_select` is high in any cycle.
- `rsp_valid` stays high, with the result stable, until `rsp_ready` arrives. No timeout.

## Timing
- Reset (`clear`=0, asynchronous): state=IDLE, and all outputs go to 0 immediately, except `cmd_ready`=1 once in IDLE. Latched op/a/b are zeroed.
- Reset mid-operation: any strobe is dropped at once and no partial response is issued. The datapath registers are cleared by their own `clear`.
- Accept edge T:
  - LOAD_A in cycle T+1.
  - LOAD_B in T+2.
  - EXEC in T+3..T+2+EXEC_CYCLES.
  - CAPT in T+3+EXEC_CYCLES.
  - `rsp_valid` first high in T+4+EXEC_CYCLES (T+5 with the default).
- Back-to-back commands:
  - A response handshake on edge R puts the block in IDLE in cycle R+1, with `cmd_ready`=1.
  - Minimum command spacing is 5+EXEC_CYCLES cycles.
- `cmd_valid` while busy is ignored (`cmd_ready`=0). It is not lost, because the producer holds it.

## Configuration
- Macro: `ALU_SEQ_ILLEGAL_OP_EN`.
- Defined:
  - A command with `cmd_op` ≥ NUM_OPS is accepted normally, then goes IDLE→RESP directly with no datapath strobes.
  - In that response, `rsp_error`=1 and `rsp_result`=0.
  - `rsp_error`=0 for every legal op.
- Undefined:
  - Every opcode is sequenced normally.
  - `rsp_error` is tied to 0.

## Structure
- Shared defs file `alu_seq_defs`:
  - state encodings for the six states.
  - select-bit indices RA_SEL=0, RB_SEL=1, RZ_SEL=2.
  - OP_W=4.
  - the datapath and control files include it.
- One natural sub-module: `alu_seq_wait_counter`, a 4-bit loadable down-counter with a zero flag, used for EXEC.

## Test plan
- Reset then op=2, a=5, b=7, EXEC_CYCLES=1 → `register_select`=0x0001 with `register_in`=5 at T+1. Then 0x0002 with `register_in`=7 at T+2, and 0x0004 at T+4. Then `rsp_valid` at T+5 with `rsp_result` equal to the model's ALU(2,5,7).
- `rsp_ready` held low for 10 cycles → `rsp_valid` and `rsp_result` stay stable, `cmd_ready`=0, and there is no further RZ strobe. Then `rsp_ready`=1 → IDLE next cycle.
- EXEC_CYCLES=4, `cmd_a`/`cmd_b` toggled after acceptance → CAPT at T+7, result uses the latched operands, and `op_select` stays stable T+1..T+8.
- `clear` pulsed low during EXEC → all outputs 0 in the same cycle. After release the block is in IDLE and a new command completes correctly.
- With `ALU_SEQ_ILLEGAL_OP_EN`, op=15, NUM_OPS=12 → `register_select` never nonzero, and `rsp_valid` is high at T+1 with `rsp_error`=1 and `rsp_result`=0. Without the macro, the same op is sequenced and `rsp_error`=0.
